// File: rtl/tx_fifo_fwft.sv
// First-word-fall-through TX FIFO between the APB write path and the UART transmitter.
// Valid/ready on both sides, fill level, almost-full/empty flags, synchronous flush and
// a sticky overflow flag. Head data is read combinationally from the storage array.
module tx_fifo_fwft #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          valid_in,
  output logic                          ready_in,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          ovf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  // Storage is deliberately not reset; empty masking keeps stale words invisible.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_count;
  logic          r_ovf;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  // Full/empty from the extra wrap bit of the pointers.
  always_comb begin
    w_wr_addr = r_wr_ptr[AW-1:0];
    w_rd_addr = r_rd_ptr[AW-1:0];
    w_empty   = (r_wr_ptr == r_rd_ptr);
    w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_addr == w_rd_addr);
  end

  // Handshake qualification; a write against a full FIFO is the overflow condition.
  always_comb begin
    w_push    = valid_in && !w_full;
    w_pop     = ready_out && !w_empty;
    w_ovf_set = valid_in && w_full;
  end

  // Storage write; flush wins so a flushed cycle leaves the array untouched.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[w_wr_addr] <= data_i;
    end
  end

  // Write pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
    end
  end

  // Read pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: moves only when exactly one of push/pop fires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PTR_ONE;
        2'b01:   r_count <= r_count - PTR_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (flush) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end
  end

  // Output decode: fall-through head masked to zero when empty, thresholds off registered count.
  always_comb begin
    ready_in     = !w_full;
    valid_out    = !w_empty;
    data_o       = w_empty ? '0 : r_mem[w_rd_addr];
    count        = r_count;
    almost_full  = (r_count >= AF_THRESH);
    almost_empty = (r_count <= AE_THRESH);
    ovf_err      = r_ovf;
  end

endmodule

// File: tb/tb_tx_fifo_fwft.sv
// Directed bench for tx_fifo_fwft (DATA_WIDTH=8, DEPTH=16, AF=12, AE=2).
module tb_tx_fifo_fwft;

  logic       clk;
  logic       rstn;
  logic       flush;
  logic [7:0] data_i;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_o;
  logic       valid_out;
  logic       ready_out;
  logic [4:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       ovf_err;

  int n_checks;
  int n_fail;

  tx_fifo_fwft #(
    .DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .data_i(data_i), .valid_in(valid_in), .ready_in(ready_in),
    .data_o(data_o), .valid_out(valid_out), .ready_out(ready_out),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in  = 1'b0;
    ready_out = 1'b0;
    flush     = 1'b0;
    data_i    = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({ready_in, valid_out, count, data_o, ovf_err, almost_full, almost_empty} !== {1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_init: rdy_in=%b vld=%b cnt=%0d dat=%h ovf=%b af=%b ae=%b, want 1 0 0 00 0 0 1",
               ready_in, valid_out, count, data_o, ovf_err, almost_full, almost_empty);
    end
    tick();
    rstn = 1'b1;
    // Load three words, then reset asynchronously mid-cycle.
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_i   = 8'(8'hD0 + i);
      tick();
    end
    valid_in = 1'b0;
    n_checks++;
    if (count !== 5'd3) begin
      n_fail++;
      $display("FAIL reset_preload_count: got %0d want 3", count);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({ready_in, valid_out, count, data_o, ovf_err} !== {1'b1, 1'b0, 5'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midstream: rdy_in=%b vld=%b cnt=%0d dat=%h ovf=%b, want 1 0 0 00 0",
               ready_in, valid_out, count, data_o, ovf_err);
    end
    #1;
    rstn = 1'b1;
    tick();
    n_checks++;
    if (valid_out !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_release: vld=%b cnt=%0d want 0 0", valid_out, count);
    end
  endtask

  task automatic test_fill_drain();
    idle_inputs();
    for (int i = 1; i <= 16; i++) begin
      valid_in = 1'b1;
      data_i   = 8'(i);
      tick();
      n_checks++;
      if (count !== 5'(i) || almost_full !== (i >= 12) || ready_in !== (i < 16) || data_o !== 8'h01) begin
        n_fail++;
        $display("FAIL fill_%0d: cnt=%0d af=%b rdy_in=%b head=%h, want cnt=%0d af=%b rdy_in=%b head=01",
                 i, count, almost_full, ready_in, data_o, i, (i >= 12), (i < 16));
      end
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      #1;
      n_checks++;
      if (data_o !== 8'(i) || valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_data_%0d: got %h vld=%b want %h vld=1", i, data_o, valid_out, 8'(i));
      end
      tick();
      n_checks++;
      if (count !== 5'(16 - i) || almost_empty !== ((16 - i) <= 2)) begin
        n_fail++;
        $display("FAIL drain_count_%0d: cnt=%0d ae=%b want cnt=%0d ae=%b",
                 i, count, almost_empty, 16 - i, ((16 - i) <= 2));
      end
    end
    ready_out = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0 || data_o !== 8'h00 || ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: vld=%b dat=%h rdy_in=%b want 0 00 1", valid_out, data_o, ready_in);
    end
  endtask

  task automatic test_overflow();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1;
      data_i   = 8'(8'h20 + i);
      tick();
    end
    n_checks++;
    if (ovf_err !== 1'b0 || ready_in !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_before: ovf=%b rdy_in=%b want 0 0", ovf_err, ready_in);
    end
    data_i = 8'hAA;
    tick();
    valid_in = 1'b0;
    n_checks++;
    if (ovf_err !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b cnt=%0d want 1 16", ovf_err, count);
    end
    ready_out = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_checks++;
      if (data_o !== 8'(8'h20 + i)) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d: got %h want %h", i, data_o, 8'(8'h20 + i));
      end
      tick();
    end
    ready_out = 1'b0;
    n_checks++;
    if (ovf_err !== 1'b1 || valid_out !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b vld=%b cnt=%0d want 1 0 0", ovf_err, valid_out, count);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_flush_clear: ovf=%b want 0", ovf_err);
    end
  endtask

  task automatic test_streaming();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_i   = 8'(8'h40 + i);
      tick();
    end
    ready_out = 1'b1;
    for (int k = 0; k < 40; k++) begin
      data_i = 8'(8'h43 + k);
      #1;
      n_checks++;
      if (data_o !== 8'(8'h40 + k) || valid_out !== 1'b1 || ready_in !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_data_%0d: got %h vld=%b rdy_in=%b want %h 1 1",
                 k, data_o, valid_out, ready_in, 8'(8'h40 + k));
      end
      tick();
      n_checks++;
      if (count !== 5'd3) begin
        n_fail++;
        $display("FAIL stream_count_%0d: got %0d want 3", k, count);
      end
    end
    valid_in = 1'b0;
    for (int k = 40; k < 43; k++) begin
      #1;
      n_checks++;
      if (data_o !== 8'(8'h40 + k)) begin
        n_fail++;
        $display("FAIL stream_tail_%0d: got %h want %h", k, data_o, 8'(8'h40 + k));
      end
      tick();
    end
    ready_out = 1'b0;
    n_checks++;
    if (count !== 5'd0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: cnt=%0d vld=%b want 0 0", count, valid_out);
    end
  endtask

  task automatic test_fwft_latency();
    idle_inputs();
    valid_in  = 1'b1;
    ready_out = 1'b1;
    data_i    = 8'h5C;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL fwft_no_passthru: vld=%b dat=%h want 0 00", valid_out, data_o);
    end
    tick();
    valid_in = 1'b0;
    n_checks++;
    if (valid_out !== 1'b1 || data_o !== 8'h5C || count !== 5'd1) begin
      n_fail++;
      $display("FAIL fwft_head: vld=%b dat=%h cnt=%0d want 1 5c 1", valid_out, data_o, count);
    end
    tick();
    ready_out = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL fwft_pop: vld=%b cnt=%0d want 0 0", valid_out, count);
    end
  endtask

  task automatic test_flush_priority();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      data_i   = 8'(8'h60 + i);
      tick();
    end
    flush     = 1'b1;
    ready_out = 1'b1;
    data_i    = 8'h99;
    tick();
    idle_inputs();
    n_checks++;
    if (count !== 5'd0 || valid_out !== 1'b0 || ovf_err !== 1'b0 || data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_prio: cnt=%0d vld=%b ovf=%b dat=%h want 0 0 0 00", count, valid_out, ovf_err, data_o);
    end
    // Flush while full with a write pending must also suppress the overflow set.
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1;
      data_i   = 8'(8'h80 + i);
      tick();
    end
    flush = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (ovf_err !== 1'b0 || count !== 5'd0 || ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: ovf=%b cnt=%0d rdy_in=%b want 0 0 1", ovf_err, count, ready_in);
    end
    valid_in = 1'b1;
    data_i   = 8'h77;
    tick();
    valid_in = 1'b0;
    n_checks++;
    if (data_o !== 8'h77 || count !== 5'd1 || valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_next_head: dat=%h cnt=%0d vld=%b want 77 1 1", data_o, count, valid_out);
    end
    ready_out = 1'b1;
    tick();
    ready_out = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_next_pop: vld=%b cnt=%0d want 0 0", valid_out, count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_streaming();
    test_fwft_latency();
    test_flush_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
